// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI burst RAM slave.
//   state_e   : controller states
//   CMD_*     : 2-bit command codes carried at the head of every frame
//   max_i()   : elaboration-time helper used to size the payload field
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PAYLOAD,
    WR_BURST,
    RD_FETCH,
    RD_SHIFT
  } state_e;

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WDATA = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_RDATA = 2'b11;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sp_ram.sv
// Single-port RAM, 2**ADDR_W x DATA_W, synchronous read with one cycle of
// latency. Contents are never reset.
//   clk     : clock
//   we_i    : write mem[addr_i] <= wdata_i
//   re_i    : rdata_o <= mem[addr_i] at this edge
//   addr_i  : shared read/write address
//   wdata_i : write data
//   rdata_o : registered read data
module spi_sp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/spi_burst_ram_slave.sv
// SPI slave in front of an internal single-port RAM. All SPI pins are
// sampled on clk. Frames are 2 command bits + PAY_W payload bits, MSB first.
// Write and read pointers auto-increment and wrap modulo the RAM depth; with
// BURST_EN, raw data words follow a write command and read data streams
// without gaps until SS_n is released.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   SS_n  : slave select, active low
//   MOSI  : serial data in
//   MISO  : serial data out, 0 outside RD_SHIFT
module spi_burst_ram_slave
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter bit BURST_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int PAY_W = max_i(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(PAY_W + 1);

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [PAY_W-2:0]  rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic [PAY_W-1:0]  frame;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  // Received bits including the one on MOSI this cycle; on a last-bit edge
  // this is the complete payload / data word.
  assign frame = {rx_q, MOSI};

  assign MISO = (state_q == RD_SHIFT) & tx_q[DATA_W-1];

  spi_sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (frame[DATA_W-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = rd_ptr_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!SS_n) state_d = CMD;
      end

      CMD: begin
        if (SS_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cmd_d = {cmd_q[0], MOSI};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (SS_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rx_d  = frame[PAY_W-2:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(PAY_W - 1)) begin
            cnt_d = '0;
            unique case (cmd_q)
              CMD_WADDR: begin
                wr_ptr_d = frame[ADDR_W-1:0];
                state_d  = CMD;
              end
              CMD_WDATA: begin
                ram_we   = 1'b1;
                ram_addr = wr_ptr_q;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                state_d  = BURST_EN ? WR_BURST : CMD;
              end
              CMD_RADDR: begin
                rd_ptr_d = frame[ADDR_W-1:0];
                state_d  = CMD;
              end
              default: begin
                // The synchronous RAM needs its address one edge ahead, so
                // the fetch is launched here; RD_FETCH then moves the
                // returned word into the shifter and bumps rd_ptr.
                ram_re  = 1'b1;
                state_d = RD_FETCH;
              end
            endcase
          end
        end
      end

      WR_BURST: begin
        if (SS_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rx_d  = frame[PAY_W-2:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d    = '0;
            ram_we   = 1'b1;
            ram_addr = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end

      RD_FETCH: begin
        // The read is committed even if SS_n rises now.
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        tx_d     = ram_rdata;
        cnt_d    = '0;
        state_d  = SS_n ? IDLE : RD_SHIFT;
      end

      RD_SHIFT: begin
        // Prefetch two bits before the end so the next word is in the RAM
        // output register by the last-bit edge.
        if (BURST_EN && cnt_q == CNT_W'(DATA_W - 2)) begin
          ram_re   = 1'b1;
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (SS_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          tx_d  = {tx_q[DATA_W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d = '0;
            if (BURST_EN) tx_d = ram_rdata;
            else          state_d = CMD;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule
